// File: rtl/psum_accumulator_pkg.sv
// Shared types and constants for the partial-sum accumulator and its quantizer.
package psum_accumulator_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  localparam int unsigned InWDef  = 19;
  localparam int unsigned AccWDef = 32;
  localparam int unsigned OutWDef = 8;

  localparam int OutMax = 127;
  localparam int OutMin = -128;

endpackage

// File: rtl/psum_accumulator_quant.sv
// Combinational round-half-up arithmetic shift, optional ReLU and saturation.
module psum_quant
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W     = AccWDef,
  parameter int unsigned OUT_W     = OutWDef,
  parameter int          OutMaxVal = OutMax,
  parameter int          OutMinVal = OutMin
) (
  input  logic signed [ACC_W-1:0] sum_i,
  input  logic        [4:0]       shift_i,
  input  logic                    relu_i,
  output logic        [OUT_W-1:0] q_o
);

  localparam logic signed [ACC_W-1:0] MaxExt = ACC_W'(OutMaxVal);
  localparam logic signed [ACC_W-1:0] MinExt = ACC_W'(OutMinVal);

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] r;

  always_comb begin
    rnd = '0;
    if (shift_i != 5'd0) begin
      rnd = ACC_W'(1) << (shift_i - 5'd1);
    end
    // Sum wraps in ACC_W like the rest of the datapath.
    r = (sum_i + rnd) >>> shift_i;
    if (relu_i && (r < 0)) begin
      r = '0;
    end
    if (r > MaxExt) begin
      q_o = MaxExt[OUT_W-1:0];
    end else if (r < MinExt) begin
      q_o = MinExt[OUT_W-1:0];
    end else begin
      q_o = r[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates grouped adder-tree partial sums, adds bias and quantizes to an activation.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned IN_W   = InWDef,
  parameter int unsigned ACC_W  = AccWDef,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned OUT_W  = OutWDef,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [CNT_W-1:0]  cfg_num_out_i,
  input  logic [4:0]        cfg_shift_i,
  input  logic              cfg_relu_i,
  input  logic [BIAS_W-1:0] bias_i,
  input  logic [IN_W-1:0]   acc_i,
  input  logic              vld_i,
  output logic [OUT_W-1:0]  data_o,
  output logic              vld_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e                  state_q;
  logic [LEN_W-1:0]        len_q, term_q;
  logic [CNT_W-1:0]        num_q, out_q;
  logic [4:0]              shift_q;
  logic                    relu_q;
  logic signed [ACC_W-1:0] bias_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum_q;
  logic                    s1_vld_q, s1_last_q;
  logic [OUT_W-1:0]        data_q;
  logic                    vld_q, done_q, err_q;

  logic signed [ACC_W-1:0] acc_ext;
  logic [OUT_W-1:0]        quant;

  assign acc_ext = ACC_W'($signed(acc_i));

  psum_quant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_quant (
    .sum_i   (sum_q),
    .shift_i (shift_q),
    .relu_i  (relu_q),
    .q_o     (quant)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      len_q     <= '0;
      term_q    <= '0;
      num_q     <= '0;
      out_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      bias_q    <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      vld_q     <= s1_vld_q;
      done_q    <= s1_vld_q & s1_last_q;
      if (s1_vld_q) begin
        data_q <= quant;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q   <= cfg_len_i;
            num_q   <= cfg_num_out_i;
            shift_q <= cfg_shift_i;
            relu_q  <= cfg_relu_i;
            bias_q  <= ACC_W'($signed(bias_i));
            acc_q   <= '0;
            term_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StAccum;
          end else if (vld_i) begin
            err_q <= 1'b1;
          end
        end
        StAccum: begin
          if (vld_i) begin
            if (term_q == len_q) begin
              sum_q    <= acc_q + acc_ext + bias_q;
              s1_vld_q <= 1'b1;
              acc_q    <= '0;
              term_q   <= '0;
              out_q    <= out_q + 1'b1;
              if (out_q == num_q) begin
                s1_last_q <= 1'b1;
                state_q   <= StDrain;
              end
            end else begin
              acc_q  <= acc_q + acc_ext;
              term_q <= term_q + 1'b1;
            end
          end
        end
        StDrain: begin
          // Leave only once done_o is visible so busy_o drops the cycle after it.
          if (done_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  cfg_len_i = '0;
  logic [15:0] cfg_num_out_i = '0;
  logic [4:0]  cfg_shift_i = '0;
  logic        cfg_relu_i = 1'b0;
  logic [15:0] bias_i = '0;
  logic [18:0] acc_i = '0;
  logic        vld_i = 1'b0;
  logic [7:0]  data_o;
  logic        vld_o, busy_o, done_o, err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .cfg_len_i     (cfg_len_i),
    .cfg_num_out_i (cfg_num_out_i),
    .cfg_shift_i   (cfg_shift_i),
    .cfg_relu_i    (cfg_relu_i),
    .bias_i        (bias_i),
    .acc_i         (acc_i),
    .vld_i         (vld_i),
    .data_o        (data_o),
    .vld_o         (vld_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int len, input int num, input int sh, input bit relu,
                             input int b);
    logic [31:0] lv, nv, sv, bv;
    lv = len; nv = num; sv = sh; bv = b;
    cfg_len_i     = lv[7:0];
    cfg_num_out_i = nv[15:0];
    cfg_shift_i   = sv[4:0];
    cfg_relu_i    = relu;
    bias_i        = bv[15:0];
    start_i       = 1'b1;
    step();
    start_i       = 1'b0;
  endtask

  // Single-term, single-output frame; expected value computed by hand at call site.
  task automatic run_single(input string tag, input int a, input int sh, input bit relu,
                            input int b, input int exp);
    logic [31:0] av, ev;
    av = a; ev = exp;
    start_frame(0, 0, sh, relu, b);
    acc_i = av[18:0];
    vld_i = 1'b1;
    step();
    vld_i = 1'b0;
    chk({tag, "_vld_early"}, {31'b0, vld_o}, 32'd0);
    step();
    chk({tag, "_vld"}, {31'b0, vld_o}, 32'd1);
    chk({tag, "_data"}, {24'b0, data_o}, {24'b0, ev[7:0]});
    chk({tag, "_done"}, {31'b0, done_o}, 32'd1);
    step();
    chk({tag, "_busy_off"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    int vals[6] = '{1, 2, 3, 4, 5, 6};

    #12;
    chk("rst_data", {24'b0, data_o}, 32'd0);
    chk("rst_vld",  {31'b0, vld_o},  32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_err",  {31'b0, err_o},  32'd0);
    rstn = 1'b1;
    step();

    // Basic single term; busy rises the cycle after start.
    run_single("basic", 5, 0, 1'b0, 0, 5);

    // len=3, shift=2, bias=20: 100+200-50+30+20 = 300 -> (302)>>>2 = 75
    start_frame(3, 0, 2, 1'b0, 20);
    chk("grp_busy", {31'b0, busy_o}, 32'd1);
    acc_i = 19'd100; vld_i = 1'b1; step();
    acc_i = 19'd200; step();
    acc_i = 19'h7FFCE; step();
    acc_i = 19'd30; step();
    vld_i = 1'b0;
    step();
    chk("grp_vld", {31'b0, vld_o}, 32'd1);
    chk("grp_data", {24'b0, data_o}, 32'd75);
    step();

    run_single("sat_pos", 1000, 0, 1'b0, 0, 127);
    run_single("sat_neg", -1000, 0, 1'b0, 0, -128);
    run_single("relu", -1000, 0, 1'b1, 0, 0);
    run_single("rnd_p6", 6, 2, 1'b0, 0, 2);
    run_single("rnd_n6", -6, 2, 1'b0, 0, -1);
    run_single("rnd_p5", 5, 2, 1'b0, 0, 1);
    run_single("bias_neg", 10, 0, 1'b0, -3, 7);

    // Frame of three 2-term groups, back-to-back: 3, 7, 11.
    start_frame(1, 2, 0, 1'b0, 0);
    vld_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      acc_i = (k <= 6) ? 19'(vals[k-1]) : 19'd99;
      step();
      if (k == 3) begin
        chk("frm_v1", {31'b0, vld_o}, 32'd1);
        chk("frm_d1", {24'b0, data_o}, 32'd3);
        chk("frm_n1", {31'b0, done_o}, 32'd0);
      end else if (k == 5) begin
        chk("frm_v2", {31'b0, vld_o}, 32'd1);
        chk("frm_d2", {24'b0, data_o}, 32'd7);
        chk("frm_n2", {31'b0, done_o}, 32'd0);
      end else if (k == 7) begin
        chk("frm_v3", {31'b0, vld_o}, 32'd1);
        chk("frm_d3", {24'b0, data_o}, 32'd11);
        chk("frm_n3", {31'b0, done_o}, 32'd1);
      end else if (k == 8) begin
        chk("frm_vend", {31'b0, vld_o}, 32'd0);
        chk("frm_busy", {31'b0, busy_o}, 32'd0);
        chk("frm_err", {31'b0, err_o}, 32'd0);
      end else begin
        chk("frm_gap", {31'b0, vld_o}, 32'd0);
      end
    end
    vld_i = 1'b0;
    step();

    // vld_i in IDLE sets err; start with vld_i clears it and drops the vld.
    vld_i = 1'b1; acc_i = 19'd1;
    step();
    vld_i = 1'b0;
    chk("err_set", {31'b0, err_o}, 32'd1);
    vld_i = 1'b1;
    start_frame(1, 0, 0, 1'b0, 0);
    vld_i = 1'b0;
    chk("err_clr", {31'b0, err_o}, 32'd0);
    chk("err_busy", {31'b0, busy_o}, 32'd1);

    // Complete a group, then reset before it emerges.
    acc_i = 19'd7; vld_i = 1'b1; step();
    acc_i = 19'd8; step();
    vld_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_data", {24'b0, data_o}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("mid_rst_vld",  {31'b0, vld_o},  32'd0);
    step();
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_vld", {31'b0, vld_o}, 32'd0);
    end

    run_single("after_rst", 42, 1, 1'b0, 0, 21);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Consumer at the output side of the 8-input pipelined adder tree.
- Takes the tree's 19-bit signed partial sums (acc_i/vld_i) and accumulates a configured number of them per output pixel, then adds a bias.
- Applies a rounding arithmetic right shift, optional ReLU, and saturation to an 8-bit signed activation.
- Runs a start-triggered frame of a configured number of outputs and flags completion.

Parameters:
IN_W, 19, partial-sum input width (signed)
ACC_W, 32, internal accumulator width (signed)
BIAS_W, 16, bias width (signed)
OUT_W, 8, output activation width (signed)
LEN_W, 8, width of terms-per-output config
CNT_W, 16, width of outputs-per-frame config

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
start_i  in  1  one-cycle frame start; accepted only in IDLE
cfg_len_i  in  LEN_W  terms per output minus 1 (0 -> 1 term)
cfg_num_out_i  in  CNT_W  outputs per frame minus 1
cfg_shift_i  in  5  right-shift amount, 0..31
cfg_relu_i  in  1  1 = clamp negatives to 0
bias_i  in  BIAS_W  signed bias, added once per output
acc_i  in  IN_W  signed partial sum from adder tree
vld_i  in  1  acc_i valid
data_o  out  OUT_W  signed quantized activation
vld_o  out  1  data_o valid (1-cycle pulse per output)
busy_o  out  1  frame in progress
done_o  out  1  1-cycle pulse, coincident with the frame's last vld_o
err_o  out  1  sticky: vld_i seen while IDLE; cleared by accepted start_i

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rstn. All registers clear. data_o=0, vld_o=0, busy_o=0, done_o=0, err_o=0. State=IDLE.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - On start_i, latch cfg_len, cfg_num_out, cfg_shift, cfg_relu and bias.
  - Clear acc, term count and output count; clear err_o; go to ACCUM.
  - busy_o rises the next cycle.
- ACCUM: each vld_i cycle:
  - If term_cnt < len: acc <= acc + sext(acc_i); term_cnt++.
  - If term_cnt == len (last term): sum_r <= acc + sext(acc_i) + sext(bias); s1_vld <= 1; acc <= 0; term_cnt <= 0; out_cnt++.
  - If it was also the last output (out_cnt == num_out), set s1_last and go to DRAIN.
  - No vld_i: hold. Back-to-back groups with no bubble are required.
- Stage 2 (s1_vld), applied to sum_r:
  - r = (shift==0) ? sum_r : (sum_r + (1<<(shift-1))) >>> shift. This is round-half-up, arithmetic shift.
  - If relu and r<0, r=0.
  - Saturate to [-128,127].
  - Register result into data_o; vld_o <= 1; done_o <= s1_last.
- Latency: last term's vld_i at cycle t -> vld_o at t+2. data_o holds its value until the next vld_o.
- DRAIN: vld_i is ignored (not accumulated, not an error). Return to IDLE when done_o asserts. busy_o deasserts the cycle after done_o.
- vld_i in IDLE: ignored and sets err_o.
- start_i outside IDLE: ignored.
- start_i and vld_i in the same IDLE cycle: start is taken, vld_i is dropped and err_o is not set.
- Width: max |sum| = 256 * 2^18 + 2^15 < 2^31, so no internal overflow at default widths. Arithmetic is two's-complement with wrap.
- Reset mid-frame: everything clears immediately. No vld_o or done_o is produced for the partial frame.

Decomposition:
- Shared package holds:
  - state enum (IDLE/ACCUM/DRAIN);
  - IN_W, ACC_W, OUT_W defaults;
  - saturation limits OUT_MAX=127, OUT_MIN=-128.
- One sub-module, psum_quant: combinational round/shift/ReLU/saturate (ACC_W -> OUT_W). It is reused by later output stages.
- Counters, FSM and pipeline registers stay in the top module.

Test Plan:
- len=0, num_out=0, shift=0, bias=0; one vld_i with acc_i=5 -> data_o=5, vld_o and done_o at t+2; busy_o low the next cycle.
- len=3, shift=2, bias=20; acc_i 100,200,-50,30 -> sum 300, (300+2)>>>2 = 75 -> data_o=75.
- Saturation/ReLU, each with len=0, shift=0:
  - acc_i=1000 -> 127;
  - acc_i=-1000 -> -128;
  - acc_i=-1000 with relu=1 -> 0.
- Rounding, shift=2: sum 6 -> 2; sum -6 -> -1; sum 5 -> 1.
- Frame: len=1, num_out=2, six consecutive vld_i with acc_i=1..6 -> vld_o pulses carrying 3, 7, 11 with no gaps between groups; done_o only with 11; extra vld_i in DRAIN ignored.
- Errors/reset:
  - vld_i in IDLE -> err_o=1, cleared by the next start_i.
  - rstn low mid-frame -> all outputs 0 and no stray vld_o after release.
  - A new frame then runs correctly.
